dpsram_bist: RTL and testbench
==============================

DPSRAM_BIST -- requirements
Module: dpsram_bist

Interface
REQ-001 The block SHALL have parameter AW, default 3, meaning SRAM address width (8 locations).
REQ-002 The block SHALL have parameter DW, default 4, meaning SRAM data width.
REQ-003 The block SHALL have parameter RD_LAT, default 1, meaning cycles from rd/ad2 issue to valid do2.
REQ-004 The block SHALL have port clk, input, 1, meaning the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rs_n, input, 1, meaning reset; it is asynchronous and active-low.
REQ-006 The block SHALL have port start, input, 1, meaning a run request, sampled only in IDLE.
REQ-007 The block SHALL have port abort, input, 1, meaning a synchronous cancel of a running test.
REQ-008 The block SHALL have port seed, input, DW, meaning the pattern seed, latched when start is accepted.
REQ-009 The block SHALL have port wr, output, 1, meaning the SRAM port-1 write strobe.
REQ-010 The block SHALL have port ad1, output, AW, meaning the SRAM port-1 write address.
REQ-011 The block SHALL have port da1, output, DW, meaning the SRAM port-1 write data.
REQ-012 The block SHALL have port rd, output, 1, meaning the SRAM port-2 read strobe.
REQ-013 The block SHALL have port ad2, output, AW, meaning the SRAM port-2 read address.
REQ-014 The block SHALL have port do2, input, DW, meaning the SRAM port-2 read data.
REQ-015 The block SHALL have port busy, output, 1, meaning a test is in progress.
REQ-016 The block SHALL have port done, output, 1, meaning a one-cycle pulse at test completion.
REQ-017 The block SHALL have port pass, output, 1, meaning the last test completed with zero errors.
REQ-018 The block SHALL have port fail, output, 1, meaning at least one mismatch occurred in the current or last test.
REQ-019 The block SHALL have port err_addr, output, AW, meaning the address of the first mismatch.
REQ-020 The block SHALL have port err_cnt, output, 4, meaning the mismatch count, saturating at 15.

Function
REQ-021 The pattern SHALL be P(a) = ({a[0],a} zero-extended/truncated to DW) XOR seed; the inverse pattern is ~P(a).
REQ-022 The FSM SHALL have states IDLE, W0, R0, D0, W1, R1, D1, DONE.
REQ-023 In IDLE with start=1, the FSM SHALL go to W0 and clear fail, pass, err_cnt and err_addr.
REQ-024 W0 SHALL run 8 cycles with wr=1, ad1 = 0..7 ascending, and da1 = P(ad1); R0 SHALL run 8 cycles with rd=1 and ad2 = 0..7.
REQ-025 D0 SHALL run RD_LAT cycles with rd=0 to drain outstanding compares.
REQ-026 W1/R1/D1 SHALL repeat W0/R0/D0 using ~P.
REQ-027 D1 SHALL be followed by DONE, and DONE by IDLE.
REQ-028 Each read SHALL compare do2 exactly RD_LAT cycles after issue against the expected pattern for that address.
REQ-029 Compares SHALL continue through D0/D1, and no compare SHALL straddle a phase change incorrectly.
REQ-030 On a mismatch, err_cnt SHALL increment (saturating at 15) and fail SHALL be set; err_addr SHALL be captured only on the first mismatch.
REQ-031 busy SHALL be 1 in W0..D1; with RD_LAT=1, busy SHALL be high for exactly 34 cycles.
REQ-032 done=1 SHALL be asserted in DONE only, for one cycle, and pass = !fail SHALL be valid from the same cycle.
REQ-033 pass, fail, err_addr and err_cnt SHALL hold until the next accepted start.
REQ-034 wr and rd SHALL never be 1 in the same cycle, and both SHALL be 0 outside W*/R*.
REQ-035 start while not in IDLE SHALL be ignored, including in DONE.
REQ-036 abort while busy SHALL go to IDLE next cycle with wr=rd=0, no done pulse, and pass=0; fail and err_* SHALL hold.
REQ-037 If abort and start are both high in IDLE, abort SHALL win and no run shall start.

Reset
REQ-038 rs_n=0 SHALL asynchronously force IDLE and clear wr, rd, ad1, ad2, da1, busy, done, pass, fail, err_addr and err_cnt to 0, including mid-operation.
REQ-039 After rs_n deasserts, the first rising edge SHALL be able to accept start.

Structure
REQ-040 Package dpsram_bist_pkg SHALL hold the state enum, default AW/DW, and the err_cnt width/saturation constant.
REQ-041 Sub-module dpsram_bist_chk SHALL hold the RD_LAT expected-data/valid delay line, the comparator and the error logging.
REQ-042 The FSM and address counter SHALL stay in the top module.

Verification
REQ-043 rs_n=0 mid-R1 SHALL clear all outputs to 0 immediately, and a restart after release SHALL complete normally.
REQ-044 seed=0 with a fault-free SRAM and start pulse: ad1 0..7 SHALL carry da1 0,9,2,B,4,D,6,F, then reads 0..7, and done SHALL occur 35 cycles after start with pass=1 and err_cnt=0.
REQ-045 seed=A with address 5 bit0 stuck-at-0: R0 mismatch -> done with fail=1, pass=0, err_cnt=1, err_addr=5.
REQ-046 Stuck-at-1 on every bit of address 2 with seed=0: errors in both read passes -> err_cnt=2 (one per pass) and err_addr=2.
REQ-047 abort in busy cycle 12 -> IDLE next cycle, busy=0, wr=rd=0, and no done pulse.
REQ-048 start held high through the whole run -> exactly one run until DONE, then a second run starts from IDLE.

Source files
------------

// File: rtl/dpsram_bist_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dpsram_bist_pkg
// Brief    : Shared state encoding and sizing constants for the SRAM BIST.
// Revision : 1.0 - initial release
// ============================================================================
package dpsram_bist_pkg;

    localparam int DEF_AW = 3;
    localparam int DEF_DW = 4;

    localparam int               ERR_W   = 4;
    localparam logic [ERR_W-1:0] ERR_MAX = 4'd15;

    typedef logic [2:0] state_t;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_W0   = 3'd1;
    localparam logic [2:0] S_R0   = 3'd2;
    localparam logic [2:0] S_D0   = 3'd3;
    localparam logic [2:0] S_W1   = 3'd4;
    localparam logic [2:0] S_R1   = 3'd5;
    localparam logic [2:0] S_D1   = 3'd6;
    localparam logic [2:0] S_DONE = 3'd7;

endpackage
`default_nettype wire

// File: rtl/dpsram_bist_chk.sv
`default_nettype none
// ============================================================================
// Module   : dpsram_bist_chk
// Brief    : Read-latency delay line, data comparator and error logging.
// Revision : 1.0 - initial release
// ============================================================================
module dpsram_bist_chk
    import dpsram_bist_pkg::*;
#(
    parameter int AW     = DEF_AW,
    parameter int DW     = DEF_DW,
    parameter int RD_LAT = 1
) (
    input  logic             clk,
    input  logic             rs_n,
    input  logic             clr_i,
    input  logic             flush_i,
    input  logic             iss_i,
    input  logic [AW-1:0]    addr_i,
    input  logic [DW-1:0]    exp_i,
    input  logic [DW-1:0]    do2_i,
    output logic             fail_o,
    output logic [AW-1:0]    err_addr_o,
    output logic [ERR_W-1:0] err_cnt_o
);

    logic [RD_LAT-1:0]         vld_q;
    logic [RD_LAT-1:0][DW-1:0] exp_q;
    logic [RD_LAT-1:0][AW-1:0] adr_q;
    logic                      w_mis;

    // The tail of the delay line lines up with do2 for the read it tracks.
    assign w_mis = vld_q[RD_LAT-1] && !flush_i && (do2_i != exp_q[RD_LAT-1]);

    always_ff @(posedge clk or negedge rs_n) begin
        if (!rs_n) begin
            vld_q <= '0;
            exp_q <= '0;
            adr_q <= '0;
        end else begin
            if (flush_i || clr_i) begin
                vld_q <= '0;
            end else begin
                vld_q[0] <= iss_i;
                for (int i = 1; i < RD_LAT; i++) begin
                    vld_q[i] <= vld_q[i-1];
                end
            end
            exp_q[0] <= exp_i;
            adr_q[0] <= addr_i;
            for (int i = 1; i < RD_LAT; i++) begin
                exp_q[i] <= exp_q[i-1];
                adr_q[i] <= adr_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rs_n) begin
        if (!rs_n) begin
            fail_o     <= 1'b0;
            err_addr_o <= '0;
            err_cnt_o  <= '0;
        end else if (clr_i) begin
            fail_o     <= 1'b0;
            err_addr_o <= '0;
            err_cnt_o  <= '0;
        end else if (w_mis) begin
            fail_o <= 1'b1;
            if (!fail_o) begin
                err_addr_o <= adr_q[RD_LAT-1];
            end
            if (err_cnt_o != ERR_MAX) begin
                err_cnt_o <= err_cnt_o + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/dpsram_bist.sv
`default_nettype none
// ============================================================================
// Module   : dpsram_bist
// Brief    : Two-pass (pattern / inverse pattern) BIST for a dual-port SRAM.
// Revision : 1.0 - initial release
// ============================================================================
module dpsram_bist
    import dpsram_bist_pkg::*;
#(
    parameter int AW     = DEF_AW,
    parameter int DW     = DEF_DW,
    parameter int RD_LAT = 1
) (
    input  logic             clk,
    input  logic             rs_n,
    input  logic             start,
    input  logic             abort,
    input  logic [DW-1:0]    seed,
    output logic             wr,
    output logic [AW-1:0]    ad1,
    output logic [DW-1:0]    da1,
    output logic             rd,
    output logic [AW-1:0]    ad2,
    input  logic [DW-1:0]    do2,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             fail,
    output logic [AW-1:0]    err_addr,
    output logic [ERR_W-1:0] err_cnt
);

    localparam int            LW      = $clog2(RD_LAT + 1);
    localparam int            CW      = (AW > LW) ? AW : LW;
    localparam logic [CW-1:0] PH_LAST = CW'((1 << AW) - 1);
    localparam logic [CW-1:0] DR_LAST = CW'(RD_LAT - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] seed_q, seed_d;
    logic          pass_q, pass_d;

    logic          w_accept;
    logic          w_flush;
    logic          w_inv;
    logic [AW-1:0] w_addr;
    logic [AW:0]   w_ext;
    logic [DW-1:0] w_pat;

    assign w_addr   = cnt_q[AW-1:0];
    assign w_ext    = {w_addr[0], w_addr};
    assign w_inv    = (state_q == S_W1) || (state_q == S_R1);
    assign w_accept = (state_q == S_IDLE) && start && !abort;
    assign w_flush  = busy && abort;

    // {a[0],a} is zero-extended or truncated to DW before the seed is applied.
    for (genvar i = 0; i < DW; i++) begin : g_pat
        if (i <= AW) begin : g_map
            assign w_pat[i] = w_ext[i] ^ seed_q[i] ^ w_inv;
        end else begin : g_pad
            assign w_pat[i] = seed_q[i] ^ w_inv;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        seed_d  = seed_q;
        pass_d  = pass_q;
        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    state_d = S_W0;
                    cnt_d   = '0;
                    seed_d  = seed;
                    pass_d  = 1'b0;
                end
            end
            S_W0, S_R0, S_W1, S_R1: begin
                if (cnt_q == PH_LAST) begin
                    state_d = state_q + 3'd1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_D0, S_D1: begin
                if (cnt_q == DR_LAST) begin
                    state_d = state_q + 3'd1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                pass_d  = !fail;
            end
            default: state_d = S_IDLE;
        endcase
        if (w_flush) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            pass_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rs_n) begin
        if (!rs_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            seed_q  <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            seed_q  <= seed_d;
            pass_q  <= pass_d;
        end
    end

    assign wr   = (state_q == S_W0) || (state_q == S_W1);
    assign rd   = (state_q == S_R0) || (state_q == S_R1);
    assign busy = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done = (state_q == S_DONE);
    assign ad1  = wr ? w_addr : '0;
    assign da1  = wr ? w_pat  : '0;
    assign ad2  = rd ? w_addr : '0;
    // Last compare lands on the D1->DONE edge, so pass is derived live in DONE.
    assign pass = done ? !fail : pass_q;

    dpsram_bist_chk #(
        .AW     (AW),
        .DW     (DW),
        .RD_LAT (RD_LAT)
    ) u_chk (
        .clk        (clk),
        .rs_n       (rs_n),
        .clr_i      (w_accept),
        .flush_i    (w_flush),
        .iss_i      (rd),
        .addr_i     (w_addr),
        .exp_i      (w_pat),
        .do2_i      (do2),
        .fail_o     (fail),
        .err_addr_o (err_addr),
        .err_cnt_o  (err_cnt)
    );

endmodule
`default_nettype wire

// File: tb/tb_dpsram_bist.sv
`default_nettype none
// ============================================================================
// Module   : tb_dpsram_bist
// Brief    : Self-checking bench for dpsram_bist with a faultable SRAM model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dpsram_bist;

    localparam int AW = 3;
    localparam int DW = 4;

    logic          clk   = 1'b0;
    logic          rs_n  = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [DW-1:0] seed  = '0;
    logic          wr, rd, busy, done, pass, fail;
    logic [AW-1:0] ad1, ad2, err_addr;
    logic [DW-1:0] da1;
    logic [DW-1:0] do2 = '0;
    logic [3:0]    err_cnt;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] mem  [8];
    logic [DW-1:0] sa0  [8];
    logic [DW-1:0] sa1  [8];
    logic [DW-1:0] flip [8];

    dpsram_bist #(.AW(AW), .DW(DW), .RD_LAT(1)) dut (
        .clk(clk), .rs_n(rs_n), .start(start), .abort(abort), .seed(seed),
        .wr(wr), .ad1(ad1), .da1(da1), .rd(rd), .ad2(ad2), .do2(do2),
        .busy(busy), .done(done), .pass(pass), .fail(fail),
        .err_addr(err_addr), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    // One-cycle-latency SRAM; faults are applied on the read path.
    always @(posedge clk) begin
        if (wr) mem[ad1] <= da1;
        if (rd) do2 <= ((mem[ad2] & ~sa0[ad2]) | sa1[ad2]) ^ flip[ad2];
    end

    function automatic logic [3:0] pat(input int a, input int ph, input logic [3:0] s);
        logic [3:0] v;
        v = 4'(((a & 1) << 3) | a) ^ s;
        return (ph != 0) ? ~v : v;
    endfunction

    task automatic clear_faults;
        for (int a = 0; a < 8; a++) begin
            sa0[a] = '0; sa1[a] = '0; flip[a] = '0;
        end
    endtask

    task automatic model(input logic [3:0] s, output int cnt, output int addr);
        cnt = 0; addr = 0;
        for (int ph = 0; ph < 2; ph++) begin
            for (int a = 0; a < 8; a++) begin
                logic [3:0] e, r;
                e = pat(a, ph, s);
                r = ((e & ~sa0[a]) | sa1[a]) ^ flip[a];
                if (r != e) begin
                    if (cnt == 0) addr = a;
                    if (cnt < 15) cnt++;
                end
            end
        end
    endtask

    // Caller is at a negedge; returns at a negedge one cycle after DONE.
    task automatic do_run(input logic [3:0] s, input string tag);
        int ecnt, eaddr, cyc, done_at, busy_n, wr_n, rd_n, bad_seq, overlap;
        model(s, ecnt, eaddr);
        start = 1'b1; seed = s;
        @(negedge clk);
        start = 1'b0; seed = ~s;
        cyc = 1; done_at = 0; busy_n = 0; wr_n = 0; rd_n = 0; bad_seq = 0; overlap = 0;
        while (done_at == 0 && cyc < 80) begin
            if (busy) busy_n++;
            if (wr && rd) overlap++;
            if (wr) begin
                if (ad1 !== 3'(wr_n % 8) || da1 !== pat(wr_n % 8, wr_n / 8, s)) bad_seq++;
                wr_n++;
            end
            if (rd) begin
                if (ad2 !== 3'(rd_n % 8)) bad_seq++;
                rd_n++;
            end
            if (done === 1'b1) done_at = cyc;
            else begin
                @(negedge clk);
                cyc++;
            end
        end
        checks++; if (done_at != 35) begin failures++; $display("FAIL %s done_cycle got=%0d want=35", tag, done_at); end
        checks++; if (busy_n != 34) begin failures++; $display("FAIL %s busy_cycles got=%0d want=34", tag, busy_n); end
        checks++; if (wr_n != 16 || rd_n != 16) begin failures++; $display("FAIL %s wr_rd_counts got=%0d/%0d want=16/16", tag, wr_n, rd_n); end
        checks++; if (bad_seq != 0) begin failures++; $display("FAIL %s addr_data_seq bad=%0d want=0", tag, bad_seq); end
        checks++; if (overlap != 0) begin failures++; $display("FAIL %s wr_rd_overlap got=%0d want=0", tag, overlap); end
        checks++; if (pass !== (ecnt == 0) || fail !== (ecnt != 0)) begin failures++; $display("FAIL %s pass_fail got=%b/%b want=%b/%b", tag, pass, fail, ecnt == 0, ecnt != 0); end
        checks++; if (err_cnt !== 4'(ecnt) || err_addr !== 3'(eaddr)) begin failures++; $display("FAIL %s err got=%0d@%0d want=%0d@%0d", tag, err_cnt, err_addr, ecnt, eaddr); end
        @(negedge clk);
        checks++; if (done !== 1'b0 || busy !== 1'b0 || pass !== (ecnt == 0) || err_cnt !== 4'(ecnt)) begin
            failures++; $display("FAIL %s post_done_hold got done=%b busy=%b pass=%b cnt=%0d want 0/0/%b/%0d", tag, done, busy, pass, err_cnt, ecnt == 0, ecnt);
        end
    endtask

    task automatic test_reset;
        clear_faults();
        rs_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if ({wr, rd, busy, done, pass, fail} !== 6'b0) begin failures++; $display("FAIL reset_ctrl got=%b want=000000", {wr, rd, busy, done, pass, fail}); end
        checks++; if (ad1 !== '0 || ad2 !== '0 || da1 !== '0) begin failures++; $display("FAIL reset_bus got=%h/%h/%h want=0/0/0", ad1, ad2, da1); end
        checks++; if (err_addr !== '0 || err_cnt !== '0) begin failures++; $display("FAIL reset_err got=%0d/%0d want=0/0", err_addr, err_cnt); end
        rs_n = 1'b1;
    endtask

    task automatic test_seed0;
        clear_faults();
        do_run(4'h0, "seed0");
    endtask

    task automatic test_stuck0;
        clear_faults();
        sa0[5] = 4'b0001;
        do_run(4'hA, "stuck0");
        checks++; if (err_cnt !== 4'd1 || err_addr !== 3'd5 || pass !== 1'b0) begin failures++; $display("FAIL stuck0_const got=%0d@%0d pass=%b want=1@5 pass=0", err_cnt, err_addr, pass); end
    endtask

    task automatic test_stuck1;
        clear_faults();
        sa1[2] = 4'hF;
        do_run(4'h0, "stuck1");
        checks++; if (err_cnt !== 4'd2 || err_addr !== 3'd2) begin failures++; $display("FAIL stuck1_const got=%0d@%0d want=2@2", err_cnt, err_addr); end
    endtask

    task automatic test_saturate;
        clear_faults();
        for (int a = 0; a < 8; a++) flip[a] = 4'h1;
        do_run(4'($urandom), "saturate");
        checks++; if (err_cnt !== 4'd15 || err_addr !== 3'd0) begin failures++; $display("FAIL saturate_const got=%0d@%0d want=15@0", err_cnt, err_addr); end
    endtask

    task automatic test_random;
        for (int it = 0; it < 5; it++) begin
            clear_faults();
            for (int k = 0; k < 2; k++) begin
                int a;
                a = $urandom_range(0, 7);
                case ($urandom_range(0, 3))
                    0: sa0[a]  = 4'($urandom);
                    1: sa1[a]  = 4'($urandom);
                    2: flip[a] = 4'($urandom);
                    default: ;
                endcase
            end
            do_run(4'($urandom), $sformatf("random%0d", it));
        end
    endtask

    task automatic test_abort;
        int dn;
        clear_faults();
        flip[0] = 4'hF;
        start = 1'b1; seed = 4'($urandom);
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c < 12; c++) @(negedge clk);
        checks++; if (busy !== 1'b1 || fail !== 1'b1) begin failures++; $display("FAIL abort_pre got busy=%b fail=%b want 1/1", busy, fail); end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++; if (busy !== 1'b0 || wr !== 1'b0 || rd !== 1'b0) begin failures++; $display("FAIL abort_idle got busy=%b wr=%b rd=%b want 0/0/0", busy, wr, rd); end
        checks++; if (pass !== 1'b0 || fail !== 1'b1 || err_cnt !== 4'd1 || err_addr !== 3'd0) begin failures++; $display("FAIL abort_hold got pass=%b fail=%b cnt=%0d addr=%0d want 0/1/1/0", pass, fail, err_cnt, err_addr); end
        dn = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) dn++;
        end
        checks++; if (dn != 0) begin failures++; $display("FAIL abort_no_done got=%0d want=0", dn); end
    endtask

    task automatic test_abort_start_idle;
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        checks++; if (busy !== 1'b0 || wr !== 1'b0) begin failures++; $display("FAIL abort_wins got busy=%b wr=%b want 0/0", busy, wr); end
        @(negedge clk);
    endtask

    task automatic test_start_held;
        int dn, done_at, wait_n;
        clear_faults();
        start = 1'b1; seed = 4'($urandom);
        dn = 0; done_at = 0;
        for (int c = 1; c <= 36; c++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                dn++;
                if (done_at == 0) done_at = c;
            end
            if (c == 36) begin
                checks++; if (busy !== 1'b0) begin failures++; $display("FAIL held_idle_after_done got busy=%b want=0", busy); end
            end
        end
        checks++; if (dn != 1 || done_at != 35) begin failures++; $display("FAIL held_one_run got dones=%0d at=%0d want 1 at 35", dn, done_at); end
        @(negedge clk);
        start = 1'b0;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL held_second_run got busy=%b want=1", busy); end
        wait_n = 0;
        while (done !== 1'b1 && wait_n < 40) begin
            @(negedge clk);
            wait_n++;
        end
        checks++; if (done !== 1'b1 || pass !== 1'b1) begin failures++; $display("FAIL held_second_done got done=%b pass=%b want 1/1", done, pass); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        logic [3:0] s;
        clear_faults();
        flip[1] = 4'h3;
        s = 4'($urandom);
        start = 1'b1; seed = s;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c < 26; c++) @(negedge clk);
        checks++; if (rd !== 1'b1 || fail !== 1'b1) begin failures++; $display("FAIL midr1_pre got rd=%b fail=%b want 1/1", rd, fail); end
        #2 rs_n = 1'b0;
        #1;
        checks++; if ({wr, rd, busy, done, pass, fail} !== 6'b0 || ad1 !== '0 || ad2 !== '0 || da1 !== '0 || err_addr !== '0 || err_cnt !== '0) begin
            failures++; $display("FAIL midr1_async_clear got ctrl=%b ad1=%h ad2=%h da1=%h ea=%0d ec=%0d want all 0", {wr, rd, busy, done, pass, fail}, ad1, ad2, da1, err_addr, err_cnt);
        end
        @(negedge clk);
        rs_n = 1'b1;
        clear_faults();
        do_run(s, "after_reset");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_seed0();
        test_stuck0();
        test_stuck1();
        test_saturate();
        test_random();
        test_abort();
        test_abort_start_idle();
        test_start_held();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
